// File: rtl/btn_event.sv
// btn_event: turns the debounced button level into click / double-click /
// long-press pulses, a long-press hold level and a wrapping event counter.
// Short low gaps (fewer than REL samples) from the debounce pulse train are
// bridged and counted as pressed time.
// Optional feature macro: BTN_EVENT_DBL_EN enables the double-click window
// (WAIT2/PRESS2, win_cnt, dbl_o). Without it a release fires click_o directly.
module btn_event #(
  parameter int unsigned REL  = 4,
  parameter int unsigned LONG = 1000,
  parameter int unsigned DBL  = 500
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       btn_i,
  output logic       click_o,
  output logic       dbl_o,
  output logic       long_o,
  output logic       hold_o,
  output logic [7:0] evt_cnt_o
);

`ifdef BTN_EVENT_DBL_EN
  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG_HOLD} state_t;
`else
  typedef enum logic [1:0] {IDLE, PRESS1, LONG_HOLD} state_t;
`endif

  state_t      state, state_next;
  logic [31:0] press_cnt, press_cnt_next;
  logic [31:0] low_cnt, low_cnt_next;
  logic [31:0] low_inc, press_inc;
  logic        release_hit, long_hit;
  logic        click_next, long_next, hold_next;
  logic [7:0]  evt_cnt_next;

`ifdef BTN_EVENT_DBL_EN
  logic [31:0] win_cnt, win_cnt_next, win_inc;
  logic        dbl_next;
`else
  logic        unused_dbl;
  assign unused_dbl = (DBL != 32'd0);
  assign dbl_o = 1'b0;
`endif

  // Shared counter arithmetic: a release is the REL-th consecutive low sample;
  // a long press is the edge on which the press counter would reach LONG.
  assign low_inc     = btn_i ? 32'd0 : low_cnt + 32'd1;
  assign press_inc   = press_cnt + 32'd1;
  assign release_hit = (low_inc == REL);
  assign long_hit    = (press_inc == LONG);
`ifdef BTN_EVENT_DBL_EN
  assign win_inc     = win_cnt + 32'd1;
`endif

  // Next-state, counter updates and next-cycle pulse values; release beats long.
  always_comb begin
    state_next     = state;
    press_cnt_next = press_cnt;
    low_cnt_next   = low_inc;
    click_next     = 1'b0;
    long_next      = 1'b0;
`ifdef BTN_EVENT_DBL_EN
    win_cnt_next   = win_cnt;
    dbl_next       = 1'b0;
`endif
    case (state)
      IDLE: begin
        low_cnt_next = 32'd0;
        if (btn_i) begin
          state_next     = PRESS1;
          press_cnt_next = 32'd1;
        end
      end
      PRESS1: begin
        press_cnt_next = press_inc;
        if (release_hit) begin
`ifdef BTN_EVENT_DBL_EN
          state_next   = WAIT2;
          win_cnt_next = 32'd0;
`else
          state_next   = IDLE;
          click_next   = 1'b1;
`endif
        end else if (long_hit) begin
          state_next = LONG_HOLD;
          long_next  = 1'b1;
        end
      end
`ifdef BTN_EVENT_DBL_EN
      WAIT2: begin
        low_cnt_next = 32'd0;
        if (btn_i) begin
          state_next     = PRESS2;
          press_cnt_next = 32'd1;
        end else begin
          win_cnt_next = win_inc;
          if (win_inc == DBL) begin
            state_next = IDLE;
            click_next = 1'b1;
          end
        end
      end
      PRESS2: begin
        press_cnt_next = press_inc;
        if (release_hit) begin
          state_next = IDLE;
          dbl_next   = 1'b1;
        end else if (long_hit) begin
          // The first press already completed, so it still counts as a click.
          state_next = LONG_HOLD;
          click_next = 1'b1;
          long_next  = 1'b1;
        end
      end
`endif
      LONG_HOLD: begin
        if (release_hit) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign hold_next = (state_next == LONG_HOLD);

`ifdef BTN_EVENT_DBL_EN
  assign evt_cnt_next = evt_cnt_o + {7'd0, click_next} + {7'd0, dbl_next}
                      + {7'd0, long_next};
`else
  assign evt_cnt_next = evt_cnt_o + {7'd0, click_next} + {7'd0, long_next};
`endif

  // State, counters and registered outputs; reset drops any pending event.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      press_cnt <= 32'd0;
      low_cnt   <= 32'd0;
      click_o   <= 1'b0;
      long_o    <= 1'b0;
      hold_o    <= 1'b0;
      evt_cnt_o <= 8'd0;
    end else begin
      state     <= state_next;
      press_cnt <= press_cnt_next;
      low_cnt   <= low_cnt_next;
      click_o   <= click_next;
      long_o    <= long_next;
      hold_o    <= hold_next;
      evt_cnt_o <= evt_cnt_next;
    end
  end

`ifdef BTN_EVENT_DBL_EN
  // Double-click window counter and registered double-click pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_cnt <= 32'd0;
      dbl_o   <= 1'b0;
    end else begin
      win_cnt <= win_cnt_next;
      dbl_o   <= dbl_next;
    end
  end
`endif

endmodule
